// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state encoding and width helpers for the FIFO write arbiter
package fifo_arb_pkg;
  typedef enum logic {IDLE, BURST} arb_state_t;
  function automatic int id_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_w(int m);
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: rotating-priority encoder; the first set req at or after ptr wins
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IW = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            found,
  output logic [IW-1:0]   idx
);
  int c;
  always_comb begin
    found = |req;
    idx = '0;
    c = 0;
    // walk from farthest to nearest offset so the nearest hit lands last
    for (int k = NREQ - 1; k >= 0; k--) begin
      c = int'(ptr) + k;
      c = (c >= NREQ) ? c - NREQ : c;
      if (req[c]) idx = IW'(c);
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst scheduler sharing the async FIFO write port
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DSIZE = 8,
  parameter int MAXBURST = 4,
  localparam int IW = id_w(NREQ),
  localparam int CW = cnt_w(MAXBURST)
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       gnt,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic [IW-1:0]         cur_id,
  output logic                  busy,
  output logic                  stall
);
  arb_state_t state_q, state_d;
  logic [IW-1:0] owner_q, owner_d, rr_ptr_q, rr_ptr_d, pick_id;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d, cnt_inc;
  logic found, done;

  rr_pick #(.NREQ(NREQ)) u_pick (.req(req), .ptr(rr_ptr_q), .found(found), .idx(pick_id));

  // gnt depends only on state and wfull, never on req, so no comb loop with requesters
  assign busy = (state_q == BURST);
  assign cur_id = owner_q;
  assign gnt = (busy && !wfull) ? NREQ'(1) << owner_q : '0;
  assign winc = req[owner_q] && gnt[owner_q];
  assign stall = busy && wfull && req[owner_q];
  assign wdata = req_data[int'(owner_q)*DSIZE +: DSIZE];
  assign cnt_inc = beat_cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_ptr_d = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    done = 1'b0;
    if (state_q == IDLE) begin
      if (found) begin
        state_d = BURST;
        owner_d = pick_id;
        beat_cnt_d = '0;
      end
    end else begin
      if (!req[owner_q]) begin
        done = 1'b1;
      end else if (winc) begin
        beat_cnt_d = cnt_inc;
        done = req_last[owner_q] || (cnt_inc == CW'(MAXBURST));
      end
      if (done) begin
        state_d = IDLE;
        rr_ptr_d = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
      end
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_ptr_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end
endmodule
